prim_xor_tree_pipe: RTL and testbench



---
 rtl/prim_xor_tree_pipe.sv | 136 +++++++++++++
 tb/tb_prim_xor_tree_pipe.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prim_xor_tree_pipe.sv
// Balanced XOR reduction of NumIn masked operands with an optional register per tree
// level, a collapsing valid/ready pipeline and a synchronous flush.
module prim_xor_tree_pipe #(
  parameter int unsigned Width    = 32,
  parameter int unsigned NumIn    = 4,
  parameter bit          Pipeline = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [NumIn*Width-1:0] data_i,
  input  logic [NumIn-1:0]       mask_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [Width-1:0]       data_o,
  output logic                   busy_o
);

  localparam int unsigned Depth     = $clog2(NumIn);
  localparam int unsigned NumStages = Pipeline ? Depth : 1;
  localparam int unsigned Leaves    = 1 << Depth;
  localparam int unsigned Nodes     = Leaves / 2;

  // Every stage keeps a full row of Nodes words; rows past the live node count stay zero.
  (* keep = "true" *) logic [Width-1:0] d_q [NumStages][Nodes];
  logic [NumStages-1:0] v_q, v_d;
  logic [NumStages-1:0] free, adv;
  logic                 accept;

  logic [Width-1:0] leaf  [Leaves];
  logic [Width-1:0] lvl   [Depth][Nodes];
  logic [Width-1:0] st_in [NumStages][Nodes];

  for (genvar k = 0; k < Leaves; k++) begin : g_leaf
    if (k < NumIn) begin : g_op
      assign leaf[k] = data_i[k*Width +: Width] & {Width{mask_i[k]}};
    end else begin : g_pad
      assign leaf[k] = '0;
    end
  end

  // lvl[l-1] is tree level l; with Pipeline its source is the previous stage register.
  for (genvar l = 1; l <= Depth; l++) begin : g_lvl
    for (genvar n = 0; n < Nodes; n++) begin : g_node
      if (n >= (Leaves >> l)) begin : g_zero
        assign lvl[l-1][n] = '0;
      end else if (l == 1) begin : g_leaf_pair
        assign lvl[0][n] = leaf[2*n] ^ leaf[2*n+1];
      end else if (Pipeline) begin : g_reg_pair
        assign lvl[l-1][n] = d_q[l-2][2*n] ^ d_q[l-2][2*n+1];
      end else begin : g_comb_pair
        assign lvl[l-1][n] = lvl[l-2][2*n] ^ lvl[l-2][2*n+1];
      end
    end
  end

  for (genvar s = 0; s < NumStages; s++) begin : g_st_in
    for (genvar n = 0; n < Nodes; n++) begin : g_node
      assign st_in[s][n] = lvl[Pipeline ? s : Depth-1][n];
    end
  end

  // Back-to-front advance chain; ready_o is combinational from ready_i.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    adv  = '0;
    free = '0;
    adv[NumStages-1]  = v_q[NumStages-1] & ready_i;
    free[NumStages-1] = ~v_q[NumStages-1] | adv[NumStages-1];
    for (int s = NumStages - 2; s >= 0; s--) begin
      adv[s]  = v_q[s] & free[s+1];
      free[s] = ~v_q[s] | adv[s];
    end
  end

  assign ready_o = free[0];
  assign accept  = valid_i & ready_o;

  always_comb begin
    v_d    = v_q;
    v_d[0] = accept | (v_q[0] & ~adv[0]);
    for (int s = 1; s < NumStages; s++) begin
      v_d[s] = adv[s-1] | (v_q[s] & ~adv[s]);
    end
    if (clear_i) begin
      v_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: non-blocking assignments for all state so every stage samples pre-edge values.
      v_q <= '0;
      // NOTE: the stage data array is reset too so data_o reads zero out of reset.
      for (int s = 0; s < NumStages; s++) begin
        for (int n = 0; n < Nodes; n++) begin
          d_q[s][n] <= '0;
        end
      end
    end else begin
      v_q <= v_d;
      if (accept && !clear_i) begin
        for (int n = 0; n < Nodes; n++) begin
          d_q[0][n] <= st_in[0][n];
        end
      end
      for (int s = 1; s < NumStages; s++) begin
        if (adv[s-1] && !clear_i) begin
          for (int n = 0; n < Nodes; n++) begin
            d_q[s][n] <= st_in[s][n];
          end
        end
      end
    end
  end

  assign valid_o = v_q[NumStages-1];
  assign data_o  = d_q[NumStages-1][0];
  assign busy_o  = |v_q;

  // Handshake stability on both sides of the block.
  property p_in_hold;
    @(posedge clk_i) disable iff (!rst_ni)
      valid_i && !ready_o |=> valid_i && $stable(data_i) && $stable(mask_i);
  endproperty
  a_in_hold: assert property (p_in_hold);

  property p_out_hold;
    @(posedge clk_i) disable iff (!rst_ni)
      valid_o && !ready_i && !clear_i |=> valid_o && $stable(data_o);
  endproperty
  a_out_hold: assert property (p_out_hold);

endmodule

// File: tb/tb_prim_xor_tree_pipe.sv
// Bench for prim_xor_tree_pipe: three configurations scored against an in-flight queue model
// (XOR of masked operands, occupancy-based ready, NumStages-cycle latency).
module tb_prim_xor_tree_pipe;
  localparam int W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear;
  logic             ready;
  logic [2:0]       vin;
  logic [16*W-1:0]  dbus;
  logic [15:0]      mbus;
  logic [2:0]       rdy_o, vld_o, bsy_o;
  logic [W-1:0]     dout [3];

  always #5 clk = ~clk;

  prim_xor_tree_pipe #(.Width(W), .NumIn(4), .Pipeline(1'b1)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .valid_i(vin[0]), .ready_o(rdy_o[0]),
    .data_i(dbus[4*W-1:0]), .mask_i(mbus[3:0]), .valid_o(vld_o[0]), .ready_i(ready),
    .data_o(dout[0]), .busy_o(bsy_o[0]));

  prim_xor_tree_pipe #(.Width(W), .NumIn(5), .Pipeline(1'b0)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .valid_i(vin[1]), .ready_o(rdy_o[1]),
    .data_i(dbus[5*W-1:0]), .mask_i(mbus[4:0]), .valid_o(vld_o[1]), .ready_i(ready),
    .data_o(dout[1]), .busy_o(bsy_o[1]));

  prim_xor_tree_pipe #(.Width(W), .NumIn(16), .Pipeline(1'b1)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .valid_i(vin[2]), .ready_o(rdy_o[2]),
    .data_i(dbus), .mask_i(mbus), .valid_o(vld_o[2]), .ready_i(ready),
    .data_o(dout[2]), .busy_o(bsy_o[2]));

  typedef struct {
    int           unit;
    logic [W-1:0] val;
    int           acc;
  } exp_t;

  exp_t         sb[$];
  int           ni[3] = '{4, 5, 16};
  int           ns[3] = '{2, 1, 4};
  int           total = 0;
  int           bad   = 0;
  int           cyc   = 0;
  bit           acc_flag[3];
  int           out_cnt[3];
  logic [W-1:0] last_out[3];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_xor(input int u);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < ni[u]; k++) begin
      if (mbus[k]) r ^= dbus[k*W +: W];
    end
    return r;
  endfunction

  // One clock: compare all units at the negedge, update the model, return at posedge+1.
  task automatic cycle();
    bit er[3];
    bit ev[3];
    bit pop[3];
    int head;
    int occ;
    bit done;
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      occ  = 0;
      head = -1;
      foreach (sb[i]) begin
        if (sb[i].unit == u) begin
          if (head < 0) head = i;
          occ++;
        end
      end
      er[u] = (occ < ns[u]) || ready;
      ev[u] = (head >= 0) && (cyc - sb[head].acc >= ns[u]);
      check($sformatf("ready_o[%0d]", u), 32'(rdy_o[u]), 32'(er[u]));
      check($sformatf("valid_o[%0d]", u), 32'(vld_o[u]), 32'(ev[u]));
      check($sformatf("busy_o[%0d]", u), 32'(bsy_o[u]), 32'(occ > 0));
      if (ev[u]) check($sformatf("data_o[%0d]", u), dout[u], sb[head].val);
      pop[u]      = ev[u] && ready;
      acc_flag[u] = vin[u] && er[u];
      if (pop[u]) begin
        last_out[u] = dout[u];
        out_cnt[u]++;
      end
    end
    for (int u = 0; u < 3; u++) begin
      done = 1'b0;
      if (pop[u]) begin
        foreach (sb[i]) begin
          if (!done && sb[i].unit == u) begin
            sb.delete(i);
            done = 1'b1;
          end
        end
      end
    end
    if (clear) begin
      sb.delete();
    end else begin
      for (int u = 0; u < 3; u++) begin
        if (acc_flag[u]) sb.push_back('{u, ref_xor(u), cyc});
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input int u, input logic [16*W-1:0] d, input logic [15:0] m);
    int n;
    n = 0;
    dbus = d;
    mbus = m;
    vin[u] = 1'b1;
    do begin
      cycle();
      n++;
    end while (!acc_flag[u] && n < 50);
    vin[u] = 1'b0;
    check("send_accept", 32'(acc_flag[u]), 32'd1);
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (sb.size() > 0 && n < bound) begin
      cycle();
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    for (int u = 0; u < 3; u++) begin
      check($sformatf("%s_valid[%0d]", tag, u), 32'(vld_o[u]), 32'd0);
      check($sformatf("%s_busy[%0d]", tag, u), 32'(bsy_o[u]), 32'd0);
      check($sformatf("%s_data[%0d]", tag, u), dout[u], '0);
    end
  endtask

  initial begin
    logic [16*W-1:0] d1;
    logic [16*W-1:0] rnd;
    logic [16*W-1:0] sdat [8];
    logic [15:0]     smsk [8];
    int              idx;
    int              base;

    rst_n = 1'b0;
    clear = 1'b0;
    ready = 1'b1;
    vin   = '0;
    dbus  = '0;
    mbus  = '0;
    for (int u = 0; u < 3; u++) begin
      out_cnt[u]  = 0;
      acc_flag[u] = 1'b0;
      last_out[u] = '0;
    end
    #1;
    check_zero_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();
    cycle();

    // Four-operand set, full mask, then only operands 0 and 2.
    d1 = '0;
    d1[4*W-1:0] = {32'hFFFF0000, 32'h0F0F0F0F, 32'h12345678, 32'hA5A5A5A5};
    send(0, d1, 16'h000F);
    drain(10);
    check("full_mask_count", 32'(out_cnt[0]), 32'd1);
    send(0, d1, 16'h0005);
    drain(10);
    check("mask_0101", last_out[0], 32'hAAAAAAAA);

    // Eight back-to-back sets with a three-cycle downstream stall.
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 16; j++) sdat[i][j*W +: W] = $urandom;
      smsk[i] = 16'($urandom);
    end
    base = out_cnt[0];
    idx  = 0;
    for (int c = 0; c < 40; c++) begin
      ready = !(c >= 3 && c < 6);
      if (idx < 8) begin
        dbus   = sdat[idx];
        mbus   = smsk[idx];
        vin[0] = 1'b1;
      end else begin
        vin[0] = 1'b0;
      end
      cycle();
      if (vin[0] && acc_flag[0]) idx++;
    end
    vin[0] = 1'b0;
    ready  = 1'b1;
    drain(10);
    check("stream_accepted", 32'(idx), 32'd8);
    check("stream_outputs", 32'(out_cnt[0] - base), 32'd8);

    // Five operands, unpipelined: one-cycle latency.
    rnd = '0;
    for (int j = 0; j < 5; j++) rnd[j*W +: W] = 32'h1;
    send(1, rnd, 16'h001F);
    cycle();
    check("five_ones_count", 32'(out_cnt[1]), 32'd1);
    check("five_ones", last_out[1], 32'h1);

    // Sixteen operands: three sets in flight, clear together with a fourth.
    base = out_cnt[2];
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 16; j++) rnd[j*W +: W] = $urandom;
      send(2, rnd, 16'($urandom));
    end
    for (int j = 0; j < 16; j++) rnd[j*W +: W] = $urandom;
    dbus   = rnd;
    mbus   = 16'hFFFF;
    vin[2] = 1'b1;
    clear  = 1'b1;
    cycle();
    vin[2] = 1'b0;
    clear  = 1'b0;
    check("clear_busy", 32'(bsy_o[2]), 32'd0);
    for (int i = 0; i < 8; i++) cycle();
    check("clear_no_output", 32'(out_cnt[2] - base), 32'd0);

    // Async reset with two sets in flight, then a clean post-reset result.
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 16; j++) rnd[j*W +: W] = $urandom;
      send(2, rnd, 16'($urandom));
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = out_cnt[2];
    for (int j = 0; j < 16; j++) rnd[j*W +: W] = $urandom;
    send(2, rnd, 16'($urandom));
    drain(10);
    check("post_reset_outputs", 32'(out_cnt[2] - base), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
